// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit time-multiplexed seven-segment scan controller
//
// Walks four BCD digits one at a time at a programmable refresh rate, presenting
// each nibble on num for a downstream registered BCD-to-segment decoder and
// driving the matching active-low anode one cycle later so both line up.
// New values are held in a pending register and applied only at frame
// boundaries, so a frame never mixes old and new digits.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (minimum 2)
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   value[15:0]  BCD digits, [3:0] is digit 0 (rightmost, an[0])
//   load         one-cycle strobe sampling value
//   num[3:0]     registered BCD nibble for the decoder
//   an[3:0]      registered active-low anode enables, at most one low
//   digit_sel    index of the digit currently on num
//   pending      an accepted value is waiting for the next frame boundary
//   frame_done   one-cycle pulse on the digit 3 -> 0 wrap
//   err          sticky: last load contained a nibble > 9
// Build option:
//   SCAN_LZ_BLANK_EN  blank leading-zero digits (digit 0 always lit)

module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  num,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        pending,
  output logic        frame_done,
  output logic        err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    num_q, num_d;
  logic [3:0]    an_q, an_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;

  logic tick;
  logic boundary;
  logic value_ok;
  logic blank;

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == 2'd3);

  always_comb begin
    value_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (value[4*i +: 4] > 4'd9) value_ok = 1'b0;
    end
  end

  // Blanking looks at the digit currently on num (idx_q/disp_q), since the
  // anode lags num by one cycle.
`ifdef SCAN_LZ_BLANK_EN
  always_comb begin
    blank = (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'd0);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    disp_d       = disp_q;
    pend_val_d   = pend_val_q;
    pending_d    = pending_q;
    err_d        = err_q;
    frame_done_d = boundary;

    // Boundary consumes the pre-edge pending value; a coincident load then
    // refills pend_val and keeps pending set for the following frame.
    if (boundary) begin
      if (pending_q) disp_d = pend_val_q;
      pending_d = 1'b0;
    end

    if (load) begin
      if (value_ok) begin
        pend_val_d = value;
        pending_d  = 1'b1;
        err_d      = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // num tracks the next digit from the next disp, so a boundary swap shows
    // the new digit 0 on the same edge.
    num_d = disp_d[{idx_d, 2'b00} +: 4];
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'd0;
      pend_val_q   <= 16'd0;
      num_q        <= 4'd0;
      an_q         <= 4'b1111;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_val_q   <= pend_val_d;
      num_q        <= num_d;
      an_q         <= an_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign num        = num_q;
  assign an         = an_q;
  assign digit_sel  = idx_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
